// File: rtl/alu_seq_pkg.sv
// ============================================================================
// Module      : alu_seq_pkg
// Description : Op/ALU-control codes and FSM state encoding for alu_sequencer.
//               ALU_SEQ_ADD32_EN enables op 1101 as a 32-bit add.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_seq_pkg;

    localparam logic [3:0] c_OP_A     = 4'h0;
    localparam logic [3:0] c_OP_B     = 4'h1;
    localparam logic [3:0] c_OP_NOTA  = 4'h2;
    localparam logic [3:0] c_OP_NOTB  = 4'h3;
    localparam logic [3:0] c_OP_ADD   = 4'h4;
    localparam logic [3:0] c_OP_ADDC  = 4'h5;
    localparam logic [3:0] c_OP_OR    = 4'h6;
    localparam logic [3:0] c_OP_AND   = 4'h7;
    localparam logic [3:0] c_OP_ZERO  = 4'h8;
    localparam logic [3:0] c_OP_ONE   = 4'h9;
    localparam logic [3:0] c_OP_ONES  = 4'hA;
    localparam logic [3:0] c_OP_CLC   = 4'hB;
    localparam logic [3:0] c_OP_STC   = 4'hC;
    localparam logic [3:0] c_OP_ADD32 = 4'hD;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EXEC  = 3'd1,
        ST_EXEC2 = 3'd2,
        ST_EXEC3 = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic logic op_supported(input logic [3:0] op);
`ifdef ALU_SEQ_ADD32_EN
        return (op <= c_OP_STC) || (op == c_OP_ADD32);
`else
        return (op <= c_OP_STC);
`endif
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_sequencer.sv
// ============================================================================
// Module      : alu_sequencer
// Description : Sequences single/multi-pass commands through an external
//               16-bit ALU. ALU_SEQ_ADD32_EN adds the 32-bit add (op 1101).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_sequencer
    import alu_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    input  logic [15:0] cmd_ahi,
    input  logic [15:0] cmd_bhi,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_aluc,
    output logic        alu_cy_in,
    input  logic [15:0] alu_z,
    input  logic        alu_cy_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_z,
    output logic        rsp_err,
    output logic        flag_cy
);

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_op;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [15:0] r_lo;
    logic        r_c0;
    logic        r_flag;
    logic        r_err;
    logic [31:0] r_z;
    logic [15:0] w_alu_a;
    logic [15:0] w_alu_b;
    logic [3:0]  w_alu_aluc;
    logic        w_is_add32;

`ifdef ALU_SEQ_ADD32_EN
    logic [15:0] r_ahi;
    logic [15:0] r_bhi;
    logic [15:0] r_hi;
    logic        r_c1;
    assign w_is_add32 = (r_op == c_OP_ADD32);
`else
    logic w_unused_hi;
    assign w_unused_hi = ^{cmd_ahi, cmd_bhi};
    assign w_is_add32  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_alu_a      = '0;
        w_alu_b      = '0;
        w_alu_aluc   = c_OP_ZERO;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_next_state = op_supported(cmd_op) ? ST_EXEC : ST_DONE;
                end
            end
            ST_EXEC: begin
                w_alu_a      = r_a;
                w_alu_b      = r_b;
                w_alu_aluc   = w_is_add32 ? c_OP_ADD : r_op;
                w_next_state = ((r_op == c_OP_ADDC) || w_is_add32) ? ST_EXEC2 : ST_DONE;
            end
            ST_EXEC2: begin
                // ADDC second pass folds the previous carry flag into the sum
                w_alu_a      = r_lo;
                w_alu_b      = {15'b0, r_flag};
                w_alu_aluc   = c_OP_ADD;
                w_next_state = ST_DONE;
`ifdef ALU_SEQ_ADD32_EN
                if (w_is_add32) begin
                    w_alu_a      = r_ahi;
                    w_alu_b      = r_bhi;
                    w_next_state = ST_EXEC3;
                end
`endif
            end
`ifdef ALU_SEQ_ADD32_EN
            ST_EXEC3: begin
                w_alu_a      = r_hi;
                w_alu_b      = {15'b0, r_c0};
                w_alu_aluc   = c_OP_ADD;
                w_next_state = ST_DONE;
            end
`endif
            ST_DONE: begin
                if (rsp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op   <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_lo   <= '0;
            r_c0   <= 1'b0;
            r_flag <= 1'b0;
            r_err  <= 1'b0;
            r_z    <= '0;
`ifdef ALU_SEQ_ADD32_EN
            r_ahi  <= '0;
            r_bhi  <= '0;
            r_hi   <= '0;
            r_c1   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_op  <= cmd_op;
                        r_a   <= cmd_a;
                        r_b   <= cmd_b;
                        r_err <= !op_supported(cmd_op);
`ifdef ALU_SEQ_ADD32_EN
                        r_ahi <= cmd_ahi;
                        r_bhi <= cmd_bhi;
`endif
                        if (!op_supported(cmd_op)) begin
                            r_z <= '0;
                        end
                    end
                end
                ST_EXEC: begin
                    r_lo <= alu_z;
                    r_c0 <= alu_cy_out;
                    case (r_op)
                        c_OP_ADD: begin
                            r_flag <= alu_cy_out;
                            r_z    <= {16'h0, alu_z};
                        end
                        c_OP_CLC: begin
                            r_flag <= 1'b0;
                            r_z    <= '0;
                        end
                        c_OP_STC: begin
                            r_flag <= 1'b1;
                            r_z    <= '0;
                        end
                        default: r_z <= {16'h0, alu_z};
                    endcase
                end
                ST_EXEC2: begin
`ifdef ALU_SEQ_ADD32_EN
                    if (w_is_add32) begin
                        r_hi <= alu_z;
                        r_c1 <= alu_cy_out;
                    end else begin
                        r_z    <= {16'h0, alu_z};
                        r_flag <= r_c0 | alu_cy_out;
                    end
`else
                    r_z    <= {16'h0, alu_z};
                    r_flag <= r_c0 | alu_cy_out;
`endif
                end
`ifdef ALU_SEQ_ADD32_EN
                ST_EXEC3: begin
                    r_z    <= {alu_z, r_lo};
                    r_flag <= r_c1 | alu_cy_out;
                end
`endif
                default: ;
            endcase
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_DONE);
    assign rsp_z     = r_z;
    assign rsp_err   = r_err;
    assign flag_cy   = r_flag;
    assign alu_a     = w_alu_a;
    assign alu_b     = w_alu_b;
    assign alu_aluc  = w_alu_aluc;
    assign alu_cy_in = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// ============================================================================
// Module      : tb_alu_sequencer
// Description : Randomized self-checking bench for alu_sequencer with a
//               behavioural ALU and reference model (honours ALU_SEQ_ADD32_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [15:0] cmd_a, cmd_b, cmd_ahi, cmd_bhi;
    logic [15:0] alu_a, alu_b, alu_z;
    logic [3:0]  alu_aluc;
    logic        alu_cy_in, alu_cy_out;
    logic        rsp_valid, rsp_ready, rsp_err, flag_cy;
    logic [31:0] rsp_z;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic m_flag;
    logic [16:0] alu_sum;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_ahi(cmd_ahi), .cmd_bhi(cmd_bhi),
        .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc), .alu_cy_in(alu_cy_in),
        .alu_z(alu_z), .alu_cy_out(alu_cy_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_z(rsp_z),
        .rsp_err(rsp_err), .flag_cy(flag_cy)
    );

    // External ALU; carry-out of non-add functions is deliberately junk
    always_comb begin
        alu_sum    = 17'(alu_a) + 17'(alu_b) + 17'(alu_cy_in);
        alu_z      = 16'h0;
        alu_cy_out = ^(alu_a ^ alu_b) | alu_a[0];
        case (alu_aluc)
            4'h0: alu_z = alu_a;
            4'h1: alu_z = alu_b;
            4'h2: alu_z = ~alu_a;
            4'h3: alu_z = ~alu_b;
            4'h4, 4'h5: begin
                alu_z      = alu_sum[15:0];
                alu_cy_out = alu_sum[16];
            end
            4'h6: alu_z = alu_a | alu_b;
            4'h7: alu_z = alu_a & alu_b;
            4'h8: alu_z = 16'h0000;
            4'h9: alu_z = 16'h0001;
            4'hA: alu_z = 16'hFFFF;
            4'hB, 4'hC: alu_z = alu_a ^ alu_b ^ 16'h5A5A;
            default: alu_z = 16'hDEAD;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] ahi, input logic [15:0] bhi,
                         output logic [31:0] z, output logic err, output int lat);
        logic [32:0] s;
        err = 1'b0;
        lat = 2;
        z   = 32'h0;
        case (op)
            4'h0: z = {16'h0, a};
            4'h1: z = {16'h0, b};
            4'h2: z = {16'h0, ~a};
            4'h3: z = {16'h0, ~b};
            4'h4: begin
                s = 33'(a) + 33'(b);
                z = {16'h0, s[15:0]};
                m_flag = s[16];
            end
            4'h5: begin
                s = 33'(a) + 33'(b) + 33'(m_flag);
                z = {16'h0, s[15:0]};
                m_flag = s[16];
                lat = 3;
            end
            4'h6: z = {16'h0, a | b};
            4'h7: z = {16'h0, a & b};
            4'h8: z = 32'h0;
            4'h9: z = 32'h1;
            4'hA: z = 32'h0000_FFFF;
            4'hB: m_flag = 1'b0;
            4'hC: m_flag = 1'b1;
`ifdef ALU_SEQ_ADD32_EN
            4'hD: begin
                s = {1'b0, ahi, a} + {1'b0, bhi, b};
                z = s[31:0];
                m_flag = s[32];
                lat = 4;
            end
`endif
            default: begin
                err = 1'b1;
                lat = 1;
            end
        endcase
    endtask

    task automatic run_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] ahi, input logic [15:0] bhi, input int hold);
        logic [31:0] ez, z0;
        logic        eerr;
        int          elat, lat;
        model(op, a, b, ahi, bhi, ez, eerr, elat);
        @(negedge clk);
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_ahi = ahi; cmd_bhi = bhi;
        @(posedge clk);
        #1;
        // Keep offering junk while busy: it must be ignored
        cmd_op = 4'($urandom); cmd_a = 16'($urandom); cmd_b = 16'($urandom);
        cmd_ahi = 16'($urandom); cmd_bhi = 16'($urandom);
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
        check($sformatf("latency op%0h", op), 32'(lat), 32'(elat));
        check($sformatf("rsp_z op%0h", op), rsp_z, ez);
        check($sformatf("rsp_err op%0h", op), 32'(rsp_err), 32'(eerr));
        check($sformatf("flag_cy op%0h", op), 32'(flag_cy), 32'(m_flag));
        check("alu_idle_done", {alu_a, 12'h0, alu_aluc}, 32'h0000_0008);
        z0 = rsp_z;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_rsp_z", rsp_z, z0);
            check("hold_valid_ready", {30'h0, rsp_valid, cmd_ready}, 32'h2);
        end
        rsp_ready = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("back_to_idle", {30'h0, cmd_ready, rsp_valid}, 32'h2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_ahi = '0; cmd_bhi = '0;
        m_flag = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_state",
              {24'h0, cmd_ready, rsp_valid, rsp_err, flag_cy, alu_aluc}, 32'h0000_0088);
        check("reset_rsp_z", rsp_z, 32'h0);

        run_cmd(4'h4, 16'hFFFF, 16'h0001, 16'h0, 16'h0, 0);
        run_cmd(4'hC, 16'h1234, 16'h4321, 16'h0, 16'h0, 0);
        run_cmd(4'h5, 16'h0010, 16'h0005, 16'h0, 16'h0, 5);
        run_cmd(4'hD, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1);
        run_cmd(4'hD, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 0);
        run_cmd(4'hC, 16'h0, 16'h0, 16'h0, 16'h0, 0);
        run_cmd(4'hE, 16'hAAAA, 16'h5555, 16'h0, 16'h0, 2);
        run_cmd(4'hF, 16'h1111, 16'h2222, 16'h0, 16'h0, 0);

        // Reset during the second ADDC pass (carry flag currently set)
        run_cmd(4'hC, 16'h0, 16'h0, 16'h0, 16'h0, 0);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 4'h5; cmd_a = 16'hFFFF; cmd_b = 16'hFFFF;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("exec2_alu_drive", {alu_a, 11'h0, alu_b[0], alu_aluc}, 32'hFFFE_0014);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        m_flag = 1'b0;
        @(negedge clk);
        check("mid_reset_state", {28'h0, cmd_ready, rsp_valid, flag_cy, rsp_err}, 32'h8);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_reset_no_rsp", 32'(rsp_valid), 32'd0);
        end

        for (int n = 0; n < 120; n++) begin
            run_cmd(4'($urandom), 16'($urandom), 16'($urandom),
                    16'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk input 1 (rising edge); rst input 1 (synchronous, active-high).
REQ-002 SHALL have cmd_valid input 1 (command offered) and cmd_ready output 1 (command accepted this cycle).
REQ-003 SHALL have cmd_op input 4 (operation) and cmd_a/cmd_b input 16 each (low operand words).
REQ-004 SHALL have cmd_ahi/cmd_bhi input 16 each (high operand words; used only by ADD32).
REQ-005 SHALL have alu_a/alu_b output 16, alu_aluc output 4 and alu_cy_in output 1 (tied 0), all driving the external ALU.
REQ-006 SHALL have alu_z input 16 and alu_cy_out input 1, both ALU results.
REQ-007 SHALL have rsp_valid output 1, rsp_ready input 1, rsp_z output 32 (result; upper half 0 except ADD32) and rsp_err output 1 (unsupported op).
REQ-008 SHALL have flag_cy output 1 (architectural carry flag).

Function
REQ-009 Op codes 0000-1100 SHALL map 1:1 onto alu_aluc: A, B, NOTA, NOTB, ADD, ADDC, OR, AND, ZERO, ONE, ONES, CLC, STC.
REQ-010 FSM states: IDLE, EXEC, EXEC2, EXEC3, DONE; cmd_ready=1 only in IDLE; a handshake in IDLE captures op and operands into internal registers.
REQ-011 Single-pass ops: IDLE->EXEC (drive ALU from registers, capture alu_z)->DONE; rsp_valid is first asserted 2 cycles after the accept edge.
REQ-012 ADD: EXEC samples alu_cy_out into flag_cy.
REQ-013 ADDC: EXEC computes a+b (carry c1); EXEC2 computes z+{15'b0,flag_cy} (carry c2); flag_cy<=c1|c2; latency 3.
REQ-014 CLC/STC: flag_cy<=0/1; rsp_z=0; all other ops hold flag_cy.
REQ-015 DONE: rsp_valid=1; rsp_z/rsp_err stable until rsp_ready=1, then ->IDLE; minimum one bubble between commands.
REQ-016 Unsupported op (1101 without macro, 1110, 1111): no ALU pass; IDLE->DONE directly; rsp_z=0, rsp_err=1, flag_cy unchanged.
REQ-017 Outside EXEC*, alu_aluc SHALL be 1000 (ZERO) and alu_a/alu_b SHALL be 0.
REQ-018 cmd_valid while not IDLE SHALL be ignored (no capture, no side effect).
REQ-019 Arithmetic is modulo 2^16 per pass (2^32 for ADD32); carries are taken only from alu_cy_out of ADD passes.

Reset
REQ-020 rst at any state, including mid-sequence, SHALL force IDLE next edge and discard the command.
REQ-021 After reset: cmd_ready=1, rsp_valid=0, rsp_z=0, rsp_err=0, flag_cy=0, alu_aluc=1000.

Configuration
REQ-022 Macro ALU_SEQ_ADD32_EN defined: op 1101=ADD32.
- EXEC: lo=a+b (c0).
- EXEC2: hi=ahi+bhi (c1).
- EXEC3: hi=hi+c0 (c2).
- rsp_z={hi,lo}; flag_cy<=c1|c2; latency 4.
REQ-023 Macro undefined: 1101 is unsupported per REQ-016; EXEC3 and hi-operand registers are not built.

Structure
REQ-024 Shared package alu_seq_pkg SHALL hold the op/aluc code constants and the FSM state encoding.
REQ-025 No sub-module; the ALU is instantiated outside and wired to the alu_* ports.

Verification
REQ-026 Reset, then ADD a=FFFF b=0001 -> rsp_z=0000_0000, flag_cy=1, rsp_valid 2 cycles after accept.
REQ-027 STC, then ADDC a=0010 b=0005 -> rsp_z=0000_0016, flag_cy=0, latency 3.
REQ-028 ADD32 a=0000_FFFF b=0000_0001 (macro on) -> rsp_z=0001_0000, flag_cy=0; same with a=FFFF_FFFF -> rsp_z=0000_0000, flag_cy=1.
REQ-029 op 1110 -> rsp_err=1, rsp_z=0, flag_cy unchanged; with macro off, 1101 gives the same result.
REQ-030 Hold rsp_ready=0 for 5 cycles -> rsp_z stable and cmd_ready=0 throughout; rst asserted in EXEC2 -> IDLE next edge, flag_cy=0, no response.
